keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Input-side counterpart of the multiplexed seven-segment display driver. It drives one row of a 4×4 matrix keypad low at a time and samples the four active-low column lines. It debounces a detected key and delivers one 4-bit key code per press through a single-cycle valid strobe. It sits between the board keypad pins and any consumer logic, typically logic that loads the display digit bus.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles per row dwell; minimum 4. A scan tick occurs on the last cycle of each dwell.
- `DEBOUNCE_TICKS`, default 4: consecutive stable scan ticks required to accept a press or a release; minimum 1.
- `REPEAT_TICKS`, default 32: scan ticks between auto-repeat strobes. Used only when auto-repeat is compiled in.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rows` output 4: row drive, active-low, exactly one bit low at all times.
- `cols` input 4: column sense, asynchronous, active-low; the board provides pull-ups.
- `key_code` output 4: code of the last accepted key, row×4 + col.
- `key_valid` output 1: one-cycle strobe; `key_code` is valid in the same cycle.
- `key_pressed` output 1: high while an accepted key is held.

## Operation
- `cols` passes through a 2-FF synchronizer. All decisions use the synchronized value `cols_s`.
- A divider counts 0..SCAN_DIV-1. Tick = (count == SCAN_DIV-1). The divider runs freely in every state.
- "Hit" means any bit of `cols_s` is low. The candidate column is the lowest-index low bit, which gives fixed priority when several keys in one row are pressed.
- FSM states:
  - SCAN
    - On a tick with no hit: advance the row index (3 wraps to 0).
    - On a tick with a hit: latch row and column, set `stable` = 1, go to DEBOUNCE. The row index is frozen.
  - DEBOUNCE
    - On each tick where the same column is still the lowest low bit: `stable`++.
    - When `stable` reaches DEBOUNCE_TICKS: load `key_code`, pulse `key_valid`, set `key_pressed`, go to HELD.
    - If DEBOUNCE_TICKS = 1, acceptance happens on the entry tick itself.
    - On any mismatch tick: go to SCAN and advance the row.
  - HELD
    - On each tick where the latched column bit is high: `rel`++. On any tick where it is low: `rel` = 0.
    - When `rel` reaches DEBOUNCE_TICKS: clear `key_pressed`, go to SCAN and advance the row.
- Keys pressed in other rows during DEBOUNCE or HELD are invisible. They are found on later scans.
- `rows` is a registered decode of the row index: bit[idx] = 0, all other bits = 1.
- Counter widths: `$clog2` of each maximum. Saturation is not required because every counter is reset on its state exit.

## Timing
- Reset values:
  - `rows` = 4'b1110
  - `key_code` = 0
  - `key_valid` = 0
  - `key_pressed` = 0
  - state = SCAN
  - all counters = 0
- Synchronizer latency is 2 cycles. A column must be stable at least 2 cycles before a tick to be seen on that tick.
- Press latency from the first hit tick to `key_valid` is (DEBOUNCE_TICKS-1)×SCAN_DIV cycles plus 1 cycle. `key_valid` is registered and asserts the cycle after the accepting tick.
- `rows` changes the cycle after the advancing tick.
- Reset asserted mid-operation clears everything immediately. No strobe is emitted after reset release until a full new debounce completes.
- `key_code` holds its value until the next accepted press.

## Configuration
- `KEYPAD_AUTOREPEAT_EN`
  - Defined: in HELD, a repeat counter increments on ticks while the key is down. On reaching REPEAT_TICKS it pulses `key_valid` with the same `key_code` and restarts from 0. It is cleared by release.
  - Not defined: exactly one `key_valid` per press. The repeat counter and REPEAT_TICKS logic are absent.

## Structure
- The shared package `keypad_pkg` holds:
  - the state enum (SCAN, DEBOUNCE, HELD)
  - constants NUM_ROWS = 4 and NUM_COLS = 4
  - the key-code typedef (4 bits)
- One sub-module, `sync_2ff`, parameterized width, used for `cols`.
- The divider, FSM, and row decode stay in the top level.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_TICKS = 3.
- Reset then idle `cols` = 4'b1111:
  - `rows` = 1110 at reset.
  - `rows` then sequences 1110→1101→1011→0111→1110, changing every 4 cycles.
  - `key_valid` is never asserted.
- Key at row 2 / col 1, stable:
  - `rows` freezes at 1011.
  - One `key_valid` with `key_code` = 9, after 3 ticks.
  - `key_pressed` = 1 until 3 release ticks, then scanning resumes at 0111.
- Bounce, col 1 low for 1 tick then high:
  - No `key_valid`.
  - Row advances on the mismatch tick.
- Row 0, cols 1 and 3 pressed together:
  - `key_code` = 1, single strobe.
- `rst_n` low during DEBOUNCE:
  - Outputs return to reset values within the same cycle.
  - No strobe after release until a fresh 3-tick debounce.
- With `KEYPAD_AUTOREPEAT_EN` and REPEAT_TICKS = 8, key held for 20 ticks after acceptance:
  - Strobes at acceptance, then 8 and 16 ticks later.
  - Exactly 3 strobes in total.

Source files
------------

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared types, constants and small helpers for the 4x4 matrix keypad scanner.
//   state_t     : scanner FSM states (SCAN, DEBOUNCE, HELD)
//   NUM_ROWS    : number of keypad rows (4)
//   NUM_COLS    : number of keypad columns (4)
//   key_code_t  : 4-bit key code, row*4 + col
//   idx_t       : 2-bit row/column index
//   lowest_low  : index of the lowest-numbered low bit of an active-low column word
//   row_drive   : active-low one-cold row drive pattern for a row index
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    typedef logic [3:0] key_code_t;
    typedef logic [1:0] idx_t;

    // Lowest-index low column wins, giving fixed priority when several keys
    // in the same row are down. Returns 0 when no bit is low; callers gate
    // the result with their own hit detection.
    function automatic idx_t lowest_low(input logic [NUM_COLS-1:0] c);
        idx_t r;
        r = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (!c[i]) begin
                r = idx_t'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_ROWS-1:0] row_drive(input idx_t idx);
        logic [NUM_ROWS-1:0] r;
        for (int i = 0; i < NUM_ROWS; i++) begin
            r[i] = (idx != idx_t'(i));
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for asynchronous level inputs.
//   clk         : destination clock
//   rst_n       : asynchronous active-low reset
//   d [WIDTH]   : asynchronous input
//   q [WIDTH]   : synchronized output, two cycles behind d
// RESET_VALUE lets the caller park the chain at the input's idle level so no
// false event appears while the flops fill after reset.
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 matrix keypad one row at a time, debounces a detected key and
// emits one key code per press with a single-cycle strobe.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   rows [4]    : row drive, active-low, exactly one bit low
//   cols [4]    : column sense, asynchronous, active-low (board pull-ups)
//   key_code[4] : last accepted key, row*4 + col; held until the next press
//   key_valid   : one-cycle strobe, key_code valid in the same cycle
//   key_pressed : high while an accepted key is held
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-strobe key_valid every
// REPEAT_TICKS scan ticks while the key stays down.
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_TICKS   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [NUM_ROWS-1:0] rows,
    input  logic [NUM_COLS-1:0] cols,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_pressed
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    // One extra value of headroom so the counter can represent DEBOUNCE_TICKS.
    localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);

    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_TICKS must be at least 1");
    end
    if (REPEAT_TICKS < 1) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_TICKS must be at least 1");
    end

    logic [NUM_COLS-1:0] cols_s;
    logic [CNT_W-1:0]    div_cnt;
    logic                tick;
    logic                hit;
    idx_t                cand;

    state_t              state;
    idx_t                row_idx;
    idx_t                col_lat;
    logic [DEB_W-1:0]    stable;
    logic [DEB_W-1:0]    rel;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    logic [REP_W-1:0]    rep;
`endif

    // Columns idle high through the pull-ups, so the chain resets to all ones.
    sync_2ff #(
        .WIDTH       (NUM_COLS),
        .RESET_VALUE ({NUM_COLS{1'b1}})
    ) u_cols_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cols),
        .q     (cols_s)
    );

    assign tick = (div_cnt == CNT_W'(SCAN_DIV - 1));
    assign hit  = ~&cols_s;
    assign cand = lowest_low(cols_s);

    // Free-running row dwell divider, independent of the FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Scanner FSM. All decisions are taken on scan ticks only. The row drive
    // is registered from the next row index so rows moves the cycle right
    // after the advancing tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SCAN;
            row_idx     <= '0;
            col_lat     <= '0;
            stable      <= '0;
            rel         <= '0;
            rows        <= row_drive(idx_t'(0));
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep         <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (!hit) begin
                            row_idx <= row_idx + 2'd1;
                            rows    <= row_drive(row_idx + 2'd1);
                        end else begin
                            col_lat <= cand;
                            stable  <= DEB_W'(1);
                            if (DEBOUNCE_TICKS == 1) begin
                                // The entry tick already satisfies the count.
                                key_code    <= {row_idx, cand};
                                key_valid   <= 1'b1;
                                key_pressed <= 1'b1;
                                rel         <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep         <= '0;
`endif
                                state       <= HELD;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    end

                    DEBOUNCE: begin
                        if (hit && (cand == col_lat)) begin
                            if (stable == DEB_W'(DEBOUNCE_TICKS - 1)) begin
                                key_code    <= {row_idx, cand};
                                key_valid   <= 1'b1;
                                key_pressed <= 1'b1;
                                rel         <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep         <= '0;
`endif
                                state       <= HELD;
                            end else begin
                                stable <= stable + DEB_W'(1);
                            end
                        end else begin
                            // Bounce or a different column took priority:
                            // abandon this row and keep scanning.
                            stable  <= '0;
                            row_idx <= row_idx + 2'd1;
                            rows    <= row_drive(row_idx + 2'd1);
                            state   <= SCAN;
                        end
                    end

                    HELD: begin
                        if (cols_s[col_lat]) begin
                            if (rel == DEB_W'(DEBOUNCE_TICKS - 1)) begin
                                key_pressed <= 1'b0;
                                rel         <= '0;
                                stable      <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                                rep         <= '0;
`endif
                                row_idx     <= row_idx + 2'd1;
                                rows        <= row_drive(row_idx + 2'd1);
                                state       <= SCAN;
                            end else begin
                                rel <= rel + DEB_W'(1);
                            end
                        end else begin
                            // Any low tick restarts the release count.
                            rel <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            if (rep == REP_W'(REPEAT_TICKS - 1)) begin
                                rep       <= '0;
                                key_valid <= 1'b1;
                            end else begin
                                rep <= rep + REP_W'(1);
                            end
`endif
                        end
                    end

                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Bench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE_TICKS = 3,
// REPEAT_TICKS = 8. A keypad matrix model turns the pressed-key set and the
// row drive into column levels. A behavioural model derived from the scanning
// rules predicts every output each cycle; directed scenarios add literal
// expectations. Honours KEYPAD_AUTOREPEAT_EN for the repeat scenario.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int DIV = 4;
    localparam int DEB = 3;
    localparam int REP = 8;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int EXP_HOLD_STROBES = 3;
`else
    localparam int EXP_HOLD_STROBES = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;
    logic [15:0] keys = '0;   // bit r*4+c set = key at row r, col c held down

    int          errors = 0;
    int          checks = 0;
    int          strobes = 0;
    logic [3:0]  last_code = '0;
    bit          model_on = 1'b0;

    always #5 clk = ~clk;

    // A column reads low when any pressed key sits on a row driven low.
    function automatic logic [3:0] matrix_cols(input logic [3:0] rw, input logic [15:0] k);
        logic [3:0] res;
        res = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!rw[r] && k[r*4+c]) begin
                    res[c] = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign cols = matrix_cols(rows, keys);

    keypad_scanner #(
        .SCAN_DIV       (DIV),
        .DEBOUNCE_TICKS (DEB),
        .REPEAT_TICKS   (REP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rows        (rows),
        .cols        (cols),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_mode;     // 0 scanning, 1 debouncing, 2 holding
    int         m_row, m_col, m_stab, m_rel, m_rep, m_cyc, m_cand;
    logic [3:0] m_h1, m_h2, m_cs, m_rows, e_code;
    logic       e_valid, e_pressed;
    bit         m_hit, m_tick, m_accept, m_advance;

    task automatic model_step();
        if (!rst_n) begin
            m_mode = 0; m_row = 0; m_col = 0; m_stab = 0; m_rel = 0; m_rep = 0; m_cyc = 0;
            m_h1 = 4'hF; m_h2 = 4'hF; m_rows = 4'b1110;
            e_code = '0; e_valid = 1'b0; e_pressed = 1'b0;
            return;
        end
        // Column levels reach the decision logic two clocks late.
        m_cs = m_h2;
        m_h2 = m_h1;
        m_h1 = matrix_cols(m_rows, keys);
        m_tick = ((m_cyc % DIV) == DIV - 1);
        m_cyc++;
        e_valid = 1'b0;
        if (!m_tick) return;

        m_hit = (m_cs != 4'hF);
        m_cand = 0;
        for (int c = 3; c >= 0; c--) if (!m_cs[c]) m_cand = c;
        m_accept = 1'b0;
        m_advance = 1'b0;
        case (m_mode)
            0: begin
                if (!m_hit) m_advance = 1'b1;
                else begin
                    m_col = m_cand;
                    m_stab = 1;
                    if (m_stab >= DEB) m_accept = 1'b1; else m_mode = 1;
                end
            end
            1: begin
                if (m_hit && m_cand == m_col) begin
                    m_stab++;
                    if (m_stab >= DEB) m_accept = 1'b1;
                end else begin
                    m_mode = 0;
                    m_advance = 1'b1;
                end
            end
            default: begin
                if (m_cs[m_col]) begin
                    m_rel++;
                    if (m_rel >= DEB) begin
                        e_pressed = 1'b0;
                        m_mode = 0;
                        m_advance = 1'b1;
                    end
                end else begin
                    m_rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    m_rep++;
                    if (m_rep >= REP) begin
                        m_rep = 0;
                        e_valid = 1'b1;
                    end
`endif
                end
            end
        endcase
        if (m_accept) begin
            e_code = 4'(m_row * 4 + m_col);
            e_valid = 1'b1;
            e_pressed = 1'b1;
            m_mode = 2;
            m_rel = 0;
            m_rep = 0;
        end
        if (m_advance) m_row = (m_row + 1) % 4;
        m_rows = 4'hF;
        m_rows[m_row] = 1'b0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Compare and strobe-count process, on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n && model_on) begin
            check4("rows", rows, m_rows);
            check4("key_code", key_code, e_code);
            check4("key_valid", {3'b0, key_valid}, {3'b0, e_valid});
            check4("key_pressed", {3'b0, key_pressed}, {3'b0, e_pressed});
        end
        if (rst_n && key_valid === 1'b1) begin
            strobes++;
            last_code = key_code;
            $display("strobe #%0d key_code=%0d at %0t", strobes, key_code, $time);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Land on the first cycle of a dwell on the target row.
    task automatic wait_row_start(input logic [3:0] target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rows !== target) break;
            step(1);
        end
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (rows === target) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_release(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (key_pressed === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit found;
        int s0;

        // Reset values.
        rst_n = 1'b0;
        keys = '0;
        step(3);
        check4("reset_rows", rows, 4'b1110);
        check4("reset_code", key_code, 4'd0);
        check4("reset_valid", {3'b0, key_valid}, 4'd0);
        check4("reset_pressed", {3'b0, key_pressed}, 4'd0);
        rst_n = 1'b1;
        model_on = 1'b1;

        // Idle scan: rows rotates every DIV cycles, no strobe.
        step(3);
        check4("idle_hold", rows, 4'b1110);
        step(1);
        check4("idle_r1", rows, 4'b1101);
        step(4);
        check4("idle_r2", rows, 4'b1011);
        step(4);
        check4("idle_r3", rows, 4'b0111);
        step(4);
        check4("idle_wrap", rows, 4'b1110);
        checkn("idle_strobes", strobes, 0);

        // Stable key at row 2 / col 1.
        s0 = strobes;
        keys = 16'h0001 << 9;
        step(20 * DIV);
        checkn("r2c1_strobes", strobes - s0, 1);
        check4("r2c1_code", last_code, 4'd9);
        check4("r2c1_rows", rows, 4'b1011);
        check4("r2c1_pressed", {3'b0, key_pressed}, 4'd1);
        keys = '0;
        wait_release(found);
        checkn("r2c1_release_seen", int'(found), 1);
        check4("r2c1_resume_rows", rows, 4'b0111);
        checkn("r2c1_single", strobes - s0, 1);

        // Bounce: col 1 low for a single tick on row 2.
        s0 = strobes;
        wait_row_start(4'b1011, found);
        checkn("bounce_row_found", int'(found), 1);
        keys = 16'h0001 << 9;
        step(4);
        keys = '0;
        step(4);
        check4("bounce_advance", rows, 4'b0111);
        check4("bounce_pressed", {3'b0, key_pressed}, 4'd0);
        step(10 * DIV);
        checkn("bounce_strobes", strobes - s0, 0);

        // Row 0, cols 1 and 3 together: lowest column wins.
        s0 = strobes;
        keys = (16'h0001 << 1) | (16'h0001 << 3);
        step(20 * DIV);
        checkn("multi_strobes", strobes - s0, 1);
        check4("multi_code", last_code, 4'd1);
        keys = '0;
        wait_release(found);
        checkn("multi_release_seen", int'(found), 1);

        // Reset during debounce of row 1 / col 0.
        keys = 16'h0001 << 4;
        wait_row_start(4'b1101, found);
        checkn("rst_row_found", int'(found), 1);
        step(5);
        rst_n = 1'b0;
        #1;
        check4("midrst_rows", rows, 4'b1110);
        check4("midrst_code", key_code, 4'd0);
        check4("midrst_valid", {3'b0, key_valid}, 4'd0);
        check4("midrst_pressed", {3'b0, key_pressed}, 4'd0);
        step(2);
        rst_n = 1'b1;
        s0 = strobes;
        step(3 * DIV);
        checkn("midrst_no_early", strobes - s0, 0);
        step(10 * DIV);
        checkn("midrst_fresh", strobes - s0, 1);
        check4("midrst_code_after", last_code, 4'd4);
        keys = '0;
        wait_release(found);
        checkn("midrst_release_seen", int'(found), 1);

        // Key held for 20 ticks after acceptance (row 3 / col 2).
        s0 = strobes;
        keys = 16'h0001 << 14;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (strobes != s0) begin
                found = 1'b1;
                break;
            end
        end
        checkn("hold_accept_seen", int'(found), 1);
        step(20 * DIV);
        keys = '0;
        wait_release(found);
        checkn("hold_release_seen", int'(found), 1);
        checkn("hold_strobes", strobes - s0, EXP_HOLD_STROBES);
        check4("hold_code", last_code, 4'd14);
        step(4 * DIV);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
